key_pulse_conditioner: RTL

Input conditioning stage that turns a raw, asynchronous, bouncing push-button into the clean single-cycle `Increase` strobe consumed by the score counters. It synchronizes the key into the `Clock` domain, debounces both edges with a programmable hold time, and emits exactly one pulse per physical press regardless of hold duration. One instance sits between each board KEY pin and the counter it drives.

---
 rtl/key_pulse_conditioner_if.sv | 9 +
 rtl/key_pulse_conditioner.sv | 107 ++++++++++
 2 files changed

// File: rtl/key_pulse_conditioner_if.sv
// Button-conditioner signal bundle: raw key level in, press strobe and debounced level out.
interface key_pulse_conditioner_if;
  logic Key;
  logic Pulse;
  logic Pressed;

  modport master (output Key, input Pulse, input Pressed);
  modport slave  (input Key, output Pulse, output Pressed);
endinterface

// File: rtl/key_pulse_conditioner.sv
// Synchronizes and debounces a raw push-button, emitting one single-cycle Pulse per accepted press
// and a registered debounced Pressed level.
module key_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  key_pulse_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               pulse_q, pulse_d;
  logic               pressed_q, pressed_d;
  logic               key_norm_c;

  assign key_norm_c = ACTIVE_LOW ? ~bus.Key : bus.Key;

  // Next-state, debounce counter and registered output decode
  always_comb begin
    s1_d      = key_norm_c;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = CHK_PRESS;
          cnt_d   = '0;
        end
      end
      CHK_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = CHK_REL;
          cnt_d   = '0;
        end
      end
      CHK_REL: begin
        // A high sample during release debounce is bounce: return without a new pulse
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pressed_d = (state_d == PRESSED) || (state_d == CHK_REL);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  assign bus.Pulse   = pulse_q;
  assign bus.Pressed = pressed_q;

endmodule
